// File: rtl/sc_mult_scheduler.sv
// sc_mult_scheduler
// Shared-resource scheduler for the bipolar stochastic multiplier. Two
// requesters hand over 4-bit operand pairs; a round-robin arbiter picks one,
// both LFSR number generators are reseeded, and the XNOR product stream is
// run for 16/32/64/128 bits. The count of ones is returned with the
// requester ID over a valid/ready result port.
//
// Ports
//   clk                      : clock, rising edge
//   rst_n                    : synchronous reset, active-high (asserting 1 resets)
//   cfg_len[1:0]             : stream length 00=16 01=32 10=64 11=128, sampled at grant
//   req0_valid/ready, a, b   : requester 0 operand handshake
//   req1_valid/ready, a, b   : requester 1 operand handshake
//   res_valid/ready          : result handshake
//   res_id                   : requester index of the result
//   res_count[CNT_W-1:0]     : number of ones in the product stream
//   busy                     : high whenever the FSM is not in IDLE
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | arbitrate; ready asserted combinationally to the winner
// LOAD  | reseed both LFSRs, clear bit counter and ones accumulator
// RUN   | one product bit per cycle until bit_idx reaches L-1
// DONE  | hold result valid until res_ready

module sc_mult_scheduler #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       cfg_len,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [3:0]       req0_a,
  input  logic [3:0]       req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [3:0]       req1_a,
  input  logic [3:0]       req1_b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_id,
  output logic [CNT_W-1:0] res_count,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic             last_grant;
  logic             job_id;
  logic [3:0]       op_a, op_b;
  logic [6:0]       last_idx;
  logic [6:0]       bit_idx;
  logic [6:0]       len_m1;
  logic [30:0]      lfsr_a, lfsr_b;
  logic [CNT_W-1:0] ones;
  logic [CNT_W-1:0] count_q;
  logic             any_valid, grant_id, take;
  logic             sn_a, sn_b, prod, last_bit;

  // With a tie the requester that was not served last wins; otherwise the
  // single valid requester wins (req1_valid alone selects 1).
  assign any_valid = req0_valid | req1_valid;
  assign grant_id  = (req0_valid && req1_valid) ? ~last_grant : req1_valid;

  assign sn_a     = (lfsr_a[30:27] < op_a);
  assign sn_b     = (lfsr_b[30:27] < op_b);
  assign prod     = ~(sn_a ^ sn_b);
  assign last_bit = (bit_idx == last_idx);

  assign res_id    = job_id;
  assign res_count = count_q;

  always_comb begin
    len_m1 = 7'd15;
    case (cfg_len)
      2'b00:   len_m1 = 7'd15;
      2'b01:   len_m1 = 7'd31;
      2'b10:   len_m1 = 7'd63;
      default: len_m1 = 7'd127;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    take       = 1'b0;
    res_valid  = 1'b0;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (any_valid) begin
          take       = 1'b1;
          req0_ready = ~grant_id;
          req1_ready = grant_id;
          state_nxt  = LOAD;
        end
      end
      LOAD: state_nxt = RUN;
      RUN:  if (last_bit) state_nxt = DONE;
      DONE: begin
        res_valid = 1'b1;
        if (res_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      last_grant <= 1'b1;
      job_id     <= 1'b0;
      op_a       <= '0;
      op_b       <= '0;
      last_idx   <= '0;
      bit_idx    <= '0;
      lfsr_a     <= 31'd1;
      lfsr_b     <= 31'd2;
      ones       <= '0;
      count_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (take) begin
            op_a       <= grant_id ? req1_a : req0_a;
            op_b       <= grant_id ? req1_b : req0_b;
            job_id     <= grant_id;
            last_grant <= grant_id;
            last_idx   <= len_m1;
          end
        end
        LOAD: begin
          lfsr_a  <= 31'd1;
          lfsr_b  <= 31'd2;
          ones    <= '0;
          bit_idx <= '0;
        end
        RUN: begin
          lfsr_a  <= {lfsr_a[29:0], lfsr_a[30] ^ lfsr_a[27]};
          lfsr_b  <= {lfsr_b[29:0], lfsr_b[30] ^ lfsr_b[2]};
          ones    <= ones + CNT_W'(prod);
          bit_idx <= bit_idx + 7'd1;
          // Final count includes the bit evaluated in this cycle.
          if (last_bit) count_q <= ones + CNT_W'(prod);
        end
        default: ;
      endcase
    end
  end

endmodule
